// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-to-writeback pipeline stage feeding the register file.
//   ALU results retire one cycle after acceptance. Loads park the stage in WAIT
//   until the data memory returns a one-cycle MemRValid pulse. If no pulse
//   arrives within MEM_TIMEOUT cycles, the load is dropped and the sticky
//   MemErr flag is set.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   ValidM                M stage presents an instruction this cycle
//   RegWriteM             instruction writes a register
//   MemtoRegM             instruction is a load
//   LoadByteM             byte load (only honoured with BYTE_LOAD_EN)
//   WA3M                  destination register
//   ALUOutM               ALU result / load address
//   MemRValid, MemRData   data memory read response
//   StallM                hold M stage (stage busy with an outstanding load)
//   RegWriteW, WA3W,      regfile write port (written on the regfile's
//   ResultW               falling edge)
//   MemErr                sticky load-timeout flag
//
// Configuration macro: BYTE_LOAD_EN. When it is defined, byte loads return a
// zero-extended byte lane of MemRData selected by ALUOutM[1:0], little-endian.
// When it is undefined, all loads return the full 32-bit MemRData.
module mem_wb_stage #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ValidM,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        LoadByteM,
  input  logic [4:0]  WA3M,
  input  logic [31:0] ALUOutM,
  input  logic        MemRValid,
  input  logic [31:0] MemRData,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [4:0]  WA3W,
  output logic [31:0] ResultW,
  output logic        MemErr
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Load context captured at acceptance and used when the data returns.
  typedef struct packed {
    logic            regwrite;
    logic [RA_W-1:0] wa3;
`ifdef BYTE_LOAD_EN
    logic            byte_ld;
    logic [1:0]      lane;
`endif
  } ld_ctx_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  ld_ctx_t           ld, ld_n;
  logic              stall_n;
  logic              regwrite_n;
  logic [RA_W-1:0]   wa3_n;
  logic [XLEN-1:0]   result_n;
  logic              memerr_n;
  logic [XLEN-1:0]   load_data_c;

`ifdef BYTE_LOAD_EN
  // Byte lane extraction for byte loads, little-endian lane order.
  always_comb begin
    load_data_c = MemRData;
    if (ld.byte_ld) begin
      case (ld.lane)
        2'd0:    load_data_c = {24'b0, MemRData[7:0]};
        2'd1:    load_data_c = {24'b0, MemRData[15:8]};
        2'd2:    load_data_c = {24'b0, MemRData[23:16]};
        default: load_data_c = {24'b0, MemRData[31:24]};
      endcase
    end
  end
`else
  // Byte loads are not supported in this build; LoadByteM has no effect.
  logic unused_loadbyte;
  assign unused_loadbyte = LoadByteM;
  assign load_data_c     = MemRData;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ld_n       = ld;
    regwrite_n = 1'b0;
    wa3_n      = WA3W;
    result_n   = ResultW;
    memerr_n   = MemErr;

    case (state)
      IDLE: begin
        if (ValidM) begin
          if (MemtoRegM) begin
            ld_n.regwrite = RegWriteM;
            ld_n.wa3      = WA3M;
`ifdef BYTE_LOAD_EN
            ld_n.byte_ld  = LoadByteM;
            ld_n.lane     = ALUOutM[1:0];
`endif
            cnt_n         = '0;
            state_n       = WAIT;
          end else begin
            regwrite_n = RegWriteM;
            wa3_n      = WA3M;
            result_n   = ALUOutM;
          end
        end
      end
      WAIT: begin
        // Returning data takes priority over a timeout in the same cycle.
        if (MemRValid) begin
          regwrite_n = ld.regwrite;
          wa3_n      = ld.wa3;
          result_n   = load_data_c;
          cnt_n      = '0;
          state_n    = IDLE;
        end else if (cnt == CNT_LAST) begin
          memerr_n = 1'b1;
          cnt_n    = '0;
          state_n  = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase

    stall_n = (state_n == WAIT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ld        <= '0;
      StallM    <= 1'b0;
      RegWriteW <= 1'b0;
      WA3W      <= '0;
      ResultW   <= '0;
      MemErr    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ld        <= ld_n;
      StallM    <= stall_n;
      RegWriteW <= regwrite_n;
      WA3W      <= wa3_n;
      ResultW   <= result_n;
      MemErr    <= memerr_n;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed scenarios plus randomized transactions,
// checked against a transaction-level model of the writeback port.
module tb_mem_wb_stage;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        ValidM, RegWriteM, MemtoRegM, LoadByteM;
  logic [4:0]  WA3M;
  logic [31:0] ALUOutM;
  logic        MemRValid;
  logic [31:0] MemRData;
  logic        StallM, RegWriteW, MemErr;
  logic [4:0]  WA3W;
  logic [31:0] ResultW;

  int n_assert = 0;
  int n_fail   = 0;

  // Model of the last retired write and the sticky error flag.
  logic [4:0]  m_wa3;
  logic [31:0] m_res;
  logic        m_err;

  mem_wb_stage #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .LoadByteM(LoadByteM), .WA3M(WA3M), .ALUOutM(ALUOutM),
    .MemRValid(MemRValid), .MemRData(MemRData),
    .StallM(StallM), .RegWriteW(RegWriteW), .WA3W(WA3W),
    .ResultW(ResultW), .MemErr(MemErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic rw, input logic stall);
    chk({tag, ".RegWriteW"}, 32'(RegWriteW), 32'(rw));
    chk({tag, ".StallM"},    32'(StallM),    32'(stall));
    chk({tag, ".WA3W"},      32'(WA3W),      32'(m_wa3));
    chk({tag, ".ResultW"},   ResultW,        m_res);
    chk({tag, ".MemErr"},    32'(MemErr),    32'(m_err));
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic rw, input logic mtr, input logic lb,
                      input logic [4:0] wa, input logic [31:0] alu,
                      input logic rv, input logic [31:0] rd);
    ValidM = v; RegWriteM = rw; MemtoRegM = mtr; LoadByteM = lb;
    WA3M = wa; ALUOutM = alu; MemRValid = rv; MemRData = rd;
    @(posedge clk);
    #1;
  endtask

  // One cycle of random M-stage inputs with no memory response (ignored while stalled).
  task automatic step_noise(input logic rv);
    step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
         5'($urandom), $urandom, rv, $urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(0, 0, 0, 0, 5'd0, 32'd0, 0, 32'd0);
    step(0, 0, 0, 0, 5'd0, 32'd0, 0, 32'd0);
    reset = 1'b0;
    m_wa3 = '0; m_res = '0; m_err = 1'b0;
  endtask

  task automatic do_alu(input string tag, input logic rw, input logic [4:0] wa,
                        input logic [31:0] val, input logic spurious);
    step(1, rw, 0, 1'($urandom), wa, val, spurious, $urandom);
    m_wa3 = wa; m_res = val;
    expect_out(tag, rw, 1'b0);
  endtask

  task automatic do_idle(input string tag, input logic spurious);
    step(0, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom,
         spurious, $urandom);
    expect_out(tag, 1'b0, 1'b0);
  endtask

  // Load whose data arrives lat cycles after acceptance (1..TIMEOUT).
  task automatic do_load(input string tag, input logic rw, input logic [4:0] wa,
                         input logic lb, input logic [31:0] addr, input int lat,
                         input logic [31:0] data);
    logic [31:0] exp_data;
    step(1, rw, 1, lb, wa, addr, 0, $urandom);
    expect_out({tag, ".accept"}, 1'b0, 1'b1);
    for (int i = 1; i < lat; i++) begin
      step_noise(1'b0);
      expect_out({tag, ".wait"}, 1'b0, 1'b1);
    end
    step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
         $urandom, 1'b1, data);
    exp_data = data;
`ifdef BYTE_LOAD_EN
    if (lb) exp_data = (data >> (int'(addr[1:0]) * 8)) & 32'h0000_00FF;
`endif
    m_wa3 = wa; m_res = exp_data;
    expect_out({tag, ".done"}, rw, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    ValidM = 0; RegWriteM = 0; MemtoRegM = 0; LoadByteM = 0;
    WA3M = '0; ALUOutM = '0; MemRValid = 0; MemRData = '0;
    m_wa3 = '0; m_res = '0; m_err = 1'b0;

    // Reset values
    do_reset();
    expect_out("reset", 1'b0, 1'b0);

    // Back-to-back ALU stream
    do_alu("alu1", 1'b1, 5'd1, 32'h10, 1'b0);
    do_alu("alu2", 1'b1, 5'd2, 32'h20, 1'b0);
    do_alu("alu3", 1'b1, 5'd3, 32'h30, 1'b0);
    do_idle("idle_after_alu", 1'b0);

    // Load with 3-cycle memory latency
    do_load("load_r5", 1'b1, 5'd5, 1'b0, 32'h0000_1000, 3, 32'hCAFE_F00D);

    // Byte load, lane 2
    do_load("byte_ld", 1'b1, 5'd9, 1'b1, 32'h0000_2002, 2, 32'h1122_3344);

    // Spurious read response while idle
    do_idle("spurious_idle", 1'b1);
    do_idle("spurious_idle2", 1'b1);

    // Data arriving on the last allowed cycle beats the timeout
    do_load("data_wins", 1'b1, 5'd7, 1'b0, 32'h0000_3000, TIMEOUT, 32'hA5A5_5A5A);

    // Reset during the second WAIT cycle drops the load
    step(1, 1, 1, 0, 5'd12, 32'h0000_4000, 0, 32'd0);
    expect_out("rstwait.accept", 1'b0, 1'b1);
    step(0, 0, 0, 0, 5'd0, 32'd0, 0, 32'd0);
    expect_out("rstwait.wait1", 1'b0, 1'b1);
    reset = 1'b1;
    step(0, 0, 0, 0, 5'd0, 32'd0, 0, 32'd0);
    reset = 1'b0;
    m_wa3 = '0; m_res = '0; m_err = 1'b0;
    expect_out("rstwait.reset", 1'b0, 1'b0);
    step(0, 0, 0, 0, 5'd0, 32'd0, 1, 32'hDEAD_BEEF);
    expect_out("rstwait.late_rvalid", 1'b0, 1'b0);

    // Randomized transaction mix
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 3))
        0, 1: do_alu("rnd_alu", 1'($urandom), 5'($urandom), $urandom, 1'($urandom));
        2:    do_idle("rnd_idle", 1'($urandom));
        default: do_load("rnd_load", 1'($urandom), 5'($urandom), 1'($urandom),
                         $urandom, int'($urandom_range(1, TIMEOUT)), $urandom);
      endcase
    end

    // Hung read: times out after TIMEOUT WAIT cycles, no writeback
    do_reset();
    do_alu("pre_to", 1'b1, 5'd4, 32'h0000_0044, 1'b0);
    step(1, 1, 1, 0, 5'd6, 32'h0000_5000, 0, 32'd0);
    expect_out("to.accept", 1'b0, 1'b1);
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      step_noise(1'b0);
      if (i == int'(TIMEOUT) - 1) m_err = 1'b1;
      expect_out("to.wait", 1'b0, (i < int'(TIMEOUT) - 1));
    end
    do_idle("to.after_spurious", 1'b1);
    do_alu("to.alu", 1'b1, 5'd8, 32'h0000_0088, 1'b0);
    do_idle("to.idle", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
